byte_packer: RTL and testbench
==============================

# byte_packer

Stream byte packer for the DCT Ethernet datapath. It accepts one byte per cycle from the MAC receive side with a valid/ready handshake and assembles the bytes into OUTPUT_BYTES-wide words for the DCT core. Short final words are flagged with byte-keep and last. Byte-lane order defaults to network (big-endian) order and can be switched to host (little-endian) order at compile time.

## Interface
- BYTE_SIZE, 8: bits per byte lane.
- OUTPUT_BYTES, 4: bytes per output word (N); must be ≥2.
- clk  in  1  sole clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- s_data  in  BYTE_SIZE  incoming byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  byte is the final byte of the packet; qualified by s_valid.
- s_ready  out  1  packer accepts the byte this cycle.
- m_data  out  OUTPUT_BYTES*BYTE_SIZE  packed word; unfilled lanes are 0.
- m_data_array  out  [OUTPUT_BYTES-1:0][BYTE_SIZE-1:0]  same content as m_data; lane i = m_data[i*BYTE_SIZE +: BYTE_SIZE].
- m_keep  out  OUTPUT_BYTES  one bit per lane; 1 = lane holds a valid byte.
- m_last  out  1  word holds the packet's final byte.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the word.

## Operation
- Handshake on both sides: transfer when valid && ready. m_data, m_keep and m_last stay stable while m_valid && !m_ready.
- Accumulator: N-lane register acc, keep register acc_keep, arrival counter cnt (0..N-1).
- Accepted byte k of a word (k = cnt) is written to lane N-1-k (default) or lane k (macro defined), and its acc_keep bit is set; cnt increments.
- Completion: an accepted byte with cnt==N-1 or s_last completes the word. {acc with new byte, keep, s_last} load the output register. m_valid goes high. acc, acc_keep and cnt clear in the same cycle.
- Output register is a single slot. It is freed by m_valid && m_ready. It can be reloaded in the same cycle it is freed.
- s_ready = !(m_valid && !m_ready && (cnt==N-1 || s_last)). Non-completing bytes are always accepted, even while the output is stalled. s_ready depends combinationally on s_last and m_ready.
- s_ready is 0 while rst_n is low.
- Packet with N·j bytes: the last word has full keep and m_last=1. No empty trailing word is emitted.
- Zero-length packets are not representable. s_last always accompanies a real byte.

## Timing
- Reset values: m_valid 0, m_data 0, m_keep 0, m_last 0, acc 0, acc_keep 0, cnt 0.
- Latency: a completing byte accepted at edge t gives m_valid=1 after edge t, visible in cycle t+1.
- Throughput: one byte per cycle sustained with m_ready=1. This yields one word every N cycles with no bubbles.
- Reset mid-operation: any partial word and any pending output word are discarded. The first byte after reset release starts a new word at k=0.
- Completing byte while output stalled: s_ready=0. The byte is held by upstream and no state changes. It is accepted in the cycle m_ready rises.
- Simultaneous output drain and completing byte: both occur in that cycle. The new word replaces the old one and m_valid stays 1.

## Configuration
- BYTE_PACKER_LE_OUT_EN undefined: network order. The first byte goes to the MSB lane (N-1), and keep fills from MSB down.
- BYTE_PACKER_LE_OUT_EN defined: host order. The first byte goes to lane 0, and keep fills from LSB up.
- Handshake and timing are identical in both builds.

## Test plan
- Default build, N=4, bytes 0x11..0x88 back-to-back, s_last on 0x88, m_ready=1:
  - m_data 0x11223344 keep 4'hF last 0, then 0x55667788 keep 4'hF last 1.
  - s_ready is held 1 throughout.
- Macro defined, same stimulus:
  - m_data 0x44332211, then 0x88776655.
  - m_data_array[0] = 0x11 on the first word.
- Partial word, default build: 6 bytes 0xA1..0xA6, last on 0xA6.
  - Second word is 0xA5A60000, keep 4'b1100, m_last 1.
  - Single-byte packet 0x5C gives 0x5C000000, keep 4'b1000, last 1.
- Backpressure: m_ready=0 for 10 cycles while 8 bytes are offered.
  - First word is held stable.
  - Bytes 5–7 are accepted.
  - s_ready=0 while byte 8 waits.
  - After m_ready rises, both words are delivered in order with no loss or duplication.
- Reset mid-word: 2 bytes are accepted, then rst_n=0 for 1 cycle.
  - All outputs are 0 after reset.
  - The next 4 bytes 0x01..0x04 produce 0x01020304 with full keep.
- Simultaneous drain/load: m_ready=1 in the same cycle a completing byte is accepted.
  - m_valid stays 1 and the word updates to the new value the next cycle.

Source files
------------

// File: rtl/byte_packer.sv
// Byte-to-word stream packer: one byte per cycle in, OUTPUT_BYTES-wide words out with keep/last.
// Lane order is network (first byte in MSB lane) unless BYTE_PACKER_LE_OUT_EN is defined (first byte in lane 0).
module byte_packer #(
    parameter int BYTE_SIZE    = 8,
    parameter int OUTPUT_BYTES = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [BYTE_SIZE-1:0]                     s_data,
    input  logic                                     s_valid,
    input  logic                                     s_last,
    output logic                                     s_ready,
    output logic [OUTPUT_BYTES*BYTE_SIZE-1:0]        m_data,
    output logic [OUTPUT_BYTES-1:0][BYTE_SIZE-1:0]   m_data_array,
    output logic [OUTPUT_BYTES-1:0]                  m_keep,
    output logic                                     m_last,
    output logic                                     m_valid,
    input  logic                                     m_ready
);

    localparam int CNT_W = $clog2(OUTPUT_BYTES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTPUT_BYTES - 1);

    logic [OUTPUT_BYTES-1:0][BYTE_SIZE-1:0] acc_q, acc_d;
    logic [OUTPUT_BYTES-1:0]                acc_keep_q, acc_keep_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic [OUTPUT_BYTES-1:0][BYTE_SIZE-1:0] m_data_q, m_data_d;
    logic [OUTPUT_BYTES-1:0]                m_keep_q, m_keep_d;
    logic                                   m_last_q, m_last_d;
    logic                                   m_valid_q, m_valid_d;

    logic [CNT_W-1:0]                       lane;
    logic                                   word_end;
    logic                                   accept;
    logic                                   complete;
    logic [OUTPUT_BYTES-1:0][BYTE_SIZE-1:0] filled;
    logic [OUTPUT_BYTES-1:0]                filled_keep;

    // Both sides transfer on valid && ready. Only a word-completing byte can be refused,
    // and only while the single output slot is occupied and not being drained this cycle.
    always_comb begin
`ifdef BYTE_PACKER_LE_OUT_EN
        lane = cnt_q;
`else
        lane = CNT_MAX - cnt_q;
`endif
        word_end = (cnt_q == CNT_MAX) || s_last;
        s_ready  = rst_n && !(m_valid_q && !m_ready && word_end);
        accept   = s_valid && s_ready;
        complete = accept && word_end;

        filled            = acc_q;
        filled[lane]      = s_data;
        filled_keep       = acc_keep_q;
        filled_keep[lane] = 1'b1;
    end

    always_comb begin
        acc_d      = acc_q;
        acc_keep_d = acc_keep_q;
        cnt_d      = cnt_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_last_d   = m_last_q;
        m_valid_d  = m_valid_q && !m_ready;

        if (accept) begin
            acc_d      = filled;
            acc_keep_d = filled_keep;
            cnt_d      = cnt_q + 1'b1;
        end

        // A completing byte bypasses the accumulator straight into the output slot.
        if (complete) begin
            m_data_d   = filled;
            m_keep_d   = filled_keep;
            m_last_d   = s_last;
            m_valid_d  = 1'b1;
            acc_d      = '0;
            acc_keep_d = '0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q      <= '0;
            acc_keep_q <= '0;
            cnt_q      <= '0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_last_q   <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            acc_keep_q <= acc_keep_d;
            cnt_q      <= cnt_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
            m_last_q   <= m_last_d;
            m_valid_q  <= m_valid_d;
        end
    end

    assign m_data       = m_data_q;
    assign m_data_array = m_data_q;
    assign m_keep       = m_keep_q;
    assign m_last       = m_last_q;
    assign m_valid      = m_valid_q;

endmodule

// File: tb/tb_byte_packer.sv
// Bench for byte_packer (N=4, 8-bit lanes); expectations follow BYTE_PACKER_LE_OUT_EN when it is defined.
// A per-cycle reference model plus a queue of hand-computed words checks every output transfer.
module tb_byte_packer;

    localparam int N  = 4;
    localparam int B  = 8;
    localparam int W  = N * B;
    localparam int SW = W + N + 1;

`ifdef BYTE_PACKER_LE_OUT_EN
    localparam logic [W-1:0] T1_W0 = 32'h44332211;
    localparam logic [W-1:0] T1_W1 = 32'h88776655;
    localparam logic [W-1:0] P_W0  = 32'hA4A3A2A1;
    localparam logic [W-1:0] P_W1  = 32'h0000A6A5;
    localparam logic [N-1:0] P_K1  = 4'b0011;
    localparam logic [W-1:0] S_W   = 32'h0000005C;
    localparam logic [N-1:0] S_K   = 4'b0001;
    localparam logic [W-1:0] BP_W0 = 32'hB4B3B2B1;
    localparam logic [W-1:0] BP_W1 = 32'hB8B7B6B5;
    localparam logic [W-1:0] R_W   = 32'h04030201;
`else
    localparam logic [W-1:0] T1_W0 = 32'h11223344;
    localparam logic [W-1:0] T1_W1 = 32'h55667788;
    localparam logic [W-1:0] P_W0  = 32'hA1A2A3A4;
    localparam logic [W-1:0] P_W1  = 32'hA5A60000;
    localparam logic [N-1:0] P_K1  = 4'b1100;
    localparam logic [W-1:0] S_W   = 32'h5C000000;
    localparam logic [N-1:0] S_K   = 4'b1000;
    localparam logic [W-1:0] BP_W0 = 32'hB1B2B3B4;
    localparam logic [W-1:0] BP_W1 = 32'hB5B6B7B8;
    localparam logic [W-1:0] R_W   = 32'h01020304;
`endif

    logic                 clk;
    logic                 rst_n;
    logic [B-1:0]         s_data;
    logic                 s_valid;
    logic                 s_last;
    logic                 s_ready;
    logic [W-1:0]         m_data;
    logic [N-1:0][B-1:0]  m_data_array;
    logic [N-1:0]         m_keep;
    logic                 m_last;
    logic                 m_valid;
    logic                 m_ready;

    int errors = 0;
    int checks = 0;

    logic [SW-1:0] exp_q[$];

    byte_packer #(.BYTE_SIZE(B), .OUTPUT_BYTES(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_data_array (m_data_array),
        .m_keep       (m_keep),
        .m_last       (m_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] data, input logic [N-1:0] keep, input logic last);
        exp_q.push_back({last, keep, data});
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [B-1:0] b, input logic last);
        bit done;
        logic r;
        done    = 0;
        s_data  = b;
        s_valid = 1'b1;
        s_last  = last;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            r = s_ready;
            @(posedge clk);
            #1;
            if (r) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: byte %h not accepted within 50 cycles", b);
        end
    endtask

    task automatic send_seq(input logic [B-1:0] first, input logic [B-1:0] step,
                            input int len, input logic with_last);
        logic [B-1:0] b;
        b = first;
        for (int i = 0; i < len; i++) begin
            send_byte(b, with_last && (i == len - 1));
            b = b + step;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [B-1:0] cur_q[$];
    logic         slot_full = 1'b0;
    logic [W-1:0] slot_data = '0;
    logic [N-1:0] slot_keep = '0;
    logic         slot_last = 1'b0;
    logic         prev_stall = 1'b0;
    logic [SW-1:0] prev_out = '0;
    logic         exp_sready;
    logic [SW-1:0] exp_item;
    logic [W-1:0] word;
    int           len;

    always @(negedge clk) begin
        exp_sready = rst_n && !(slot_full && !m_ready && ((cur_q.size() == N - 1) || s_last));
        chk("s_ready", W'(s_ready), W'(exp_sready));
        if (rst_n) begin
            chk("m_valid", W'(m_valid), W'(slot_full));
            if (slot_full) begin
                chk("model_data", m_data, slot_data);
                chk("model_array", m_data_array, slot_data);
                chk("model_keep", W'(m_keep), W'(slot_keep));
                chk("model_last", W'(m_last), W'(slot_last));
            end
            if (prev_stall)
                chk("stall_stable", W'({m_last, m_keep, m_data} != prev_out), '0);
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: word %h with no expected entry", m_data);
                end else begin
                    exp_item = exp_q.pop_front();
                    chk("sb_data", m_data, exp_item[W-1:0]);
                    chk("sb_array", m_data_array, exp_item[W-1:0]);
                    chk("sb_keep", W'(m_keep), W'(exp_item[W+N-1:W]));
                    chk("sb_last", W'(m_last), W'(exp_item[SW-1]));
                end
            end
        end

        prev_stall = rst_n && m_valid && !m_ready;
        prev_out   = {m_last, m_keep, m_data};

        // predict state after the coming rising edge
        if (!rst_n) begin
            cur_q.delete();
            slot_full = 1'b0;
        end else begin
            if (slot_full && m_ready) slot_full = 1'b0;
            if (s_valid && exp_sready) begin
                cur_q.push_back(s_data);
                if (cur_q.size() == N || s_last) begin
                    len  = cur_q.size();
                    word = '0;
`ifdef BYTE_PACKER_LE_OUT_EN
                    for (int j = 0; j < len; j++) word = word | (W'(cur_q[j]) << (j * B));
                    slot_keep = N'((1 << len) - 1);
`else
                    for (int j = 0; j < len; j++) word = (word << B) | W'(cur_q[j]);
                    word      = word << ((N - len) * B);
                    slot_keep = N'(((1 << len) - 1) << (N - len));
`endif
                    slot_data = word;
                    slot_last = s_last;
                    slot_full = 1'b1;
                    cur_q.delete();
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        idle(3);
        @(negedge clk);
        chk("rst_m_valid", W'(m_valid), '0);
        chk("rst_m_data", m_data, '0);
        chk("rst_m_keep", W'(m_keep), '0);
        chk("rst_m_last", W'(m_last), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // back-to-back full words
        push_exp(T1_W0, 4'hF, 1'b0);
        push_exp(T1_W1, 4'hF, 1'b1);
        send_seq(8'h11, 8'h11, 8, 1'b1);
        idle(3);

        // partial final word, then single-byte packet
        push_exp(P_W0, 4'hF, 1'b0);
        push_exp(P_W1, P_K1, 1'b1);
        send_seq(8'hA1, 8'h01, 6, 1'b1);
        push_exp(S_W, S_K, 1'b1);
        send_seq(8'h5C, 8'h00, 1, 1'b1);
        idle(3);

        // backpressure, ending with simultaneous drain and load
        push_exp(BP_W0, 4'hF, 1'b0);
        push_exp(BP_W1, 4'hF, 1'b1);
        m_ready = 1'b0;
        fork
            send_seq(8'hB1, 8'h01, 8, 1'b1);
            begin
                repeat (9) @(posedge clk);
                @(negedge clk);
                chk("bp_s_ready_held", W'(s_ready), '0);
                chk("bp_word0_held", m_data, BP_W0);
                @(posedge clk);
                #1 m_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("bp_swap_valid", W'(m_valid), 1);
                chk("bp_swap_data", m_data, BP_W1);
            end
        join
        idle(3);

        // reset in the middle of a word
        send_seq(8'hE1, 8'h01, 2, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_m_valid", W'(m_valid), '0);
        chk("mid_rst_m_data", m_data, '0);
        chk("mid_rst_m_keep", W'(m_keep), '0);
        chk("mid_rst_m_last", W'(m_last), '0);
        @(posedge clk);
        #1;
        push_exp(R_W, 4'hF, 1'b0);
        send_seq(8'h01, 8'h01, 4, 1'b0);
        idle(4);

        chk("sb_drained", W'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
